// File: rtl/lh_pkg.sv
// Shared definitions for the light-hash driver and hash core: FSM state
// encoding, digest width, ASCII class bounds and the alphanumeric test.
package lh_pkg;

    localparam int unsigned DIGEST_W = 64;

    localparam logic [7:0] NULL_CHAR = 8'h00;
    localparam logic [7:0] ASCII_0   = 8'h30;  // '0'
    localparam logic [7:0] ASCII_9   = 8'h39;  // '9'
    localparam logic [7:0] ASCII_UA  = 8'h41;  // 'A'
    localparam logic [7:0] ASCII_UZ  = 8'h5A;  // 'Z'
    localparam logic [7:0] ASCII_LA  = 8'h61;  // 'a'
    localparam logic [7:0] ASCII_LZ  = 8'h7A;  // 'z'

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_SCAN  = 3'd4
    } lh_drv_state_e;

    // True for [0-9A-Za-z].
    function automatic logic is_alnum(input logic [7:0] c);
        return ((c >= ASCII_0)  && (c <= ASCII_9))  ||
               ((c >= ASCII_UA) && (c <= ASCII_UZ)) ||
               ((c >= ASCII_LA) && (c <= ASCII_LZ));
    endfunction

endpackage

// File: rtl/lh_msg_buf.sv
// Message buffer: DEPTH x 8-bit register array, synchronous write,
// combinational read. Contents are deliberately not reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_addr  in   read address
//   rd_data  out  byte at rd_addr (combinational)
module lh_msg_buf #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Byte write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lh_hash_driver.sv
// Light-hash driver: buffers a message, streams it one byte per cycle to the
// hash core, waits (bounded) for the digest, captures it and compares it with
// the expected digest supplied at start.
// Optional feature macro: LH_DRV_PRECHECK_EN -- adds a SCAN state that checks
// every message byte is [0-9A-Za-z] before anything is sent.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   msg_wr_en/addr/data      buffer write port (ignored while busy)
//   msg_len, exp_digest      job parameters, sampled on accepted start
//   start                    launch request, accepted only when idle
//   ptxt_char, ptxt_valid    byte stream to the hash core
//   digest_char, digest_ready digest from the core
//   err_invalid_ptxt_char    core error flag, one cycle behind its byte
//   busy, done               activity level / one-cycle completion pulse
//   digest_out, match        captured digest and comparison result
//   err_len, err_invalid, err_timeout  sticky result flags
module lh_hash_driver
    import lh_pkg::*;
#(
    parameter int unsigned MSG_MAX_LEN    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned AW = $clog2(MSG_MAX_LEN),
    localparam int unsigned LW = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                msg_wr_en,
    input  logic [AW-1:0]       msg_wr_addr,
    input  logic [7:0]          msg_wr_data,
    input  logic [LW-1:0]       msg_len,
    input  logic [DIGEST_W-1:0] exp_digest,
    input  logic                start,
    output logic [7:0]          ptxt_char,
    output logic                ptxt_valid,
    input  logic [DIGEST_W-1:0] digest_char,
    input  logic                digest_ready,
    input  logic                err_invalid_ptxt_char,
    output logic                busy,
    output logic                done,
    output logic [DIGEST_W-1:0] digest_out,
    output logic                match,
    output logic                err_len,
    output logic                err_invalid,
    output logic                err_timeout
);

    // WAIT counter must reach TIMEOUT_CYCLES itself.
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    lh_drv_state_e state, state_next;

    logic [LW-1:0]       idx;
    logic [LW-1:0]       len_q;
    logic [CW-1:0]       cnt;
    logic [DIGEST_W-1:0] exp_q;
    logic                last_valid;

    logic [AW-1:0]       rd_addr;
    logic [7:0]          rd_data;

    logic                accept;
    logic                len_bad;
    logic                wait_hit;
    logic                wait_expire;
    logic                scan_bad;
    logic                err_inv_hit;
    logic                match_c;
    logic [DIGEST_W-1:0] digest_nx;

    // Message buffer; frozen while a job is in flight.
    lh_msg_buf #(
        .DEPTH (MSG_MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .wr_en   (msg_wr_en && !busy),
        .wr_addr (msg_wr_addr),
        .wr_data (msg_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Idle always presents byte 0 so the first byte can load on the start edge.
    assign rd_addr = (state == ST_IDLE) ? '0 : idx[AW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        wait_hit    = 1'b0;
        wait_expire = 1'b0;
        scan_bad    = 1'b0;
        len_bad     = (msg_len == '0) || (msg_len > LW'(MSG_MAX_LEN));
        err_inv_hit = last_valid && err_invalid_ptxt_char;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len_bad) begin
                        state_next = ST_CHECK;
                    end else begin
`ifdef LH_DRV_PRECHECK_EN
                        state_next = ST_SCAN;
`else
                        state_next = ST_SEND;
`endif
                    end
                end
            end
            ST_SEND: begin
                if (idx == len_q) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A digest arriving on the last allowed cycle beats the timeout.
                if (digest_ready) begin
                    wait_hit   = 1'b1;
                    state_next = ST_CHECK;
                end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
                    wait_expire = 1'b1;
                    state_next  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
            end
`ifdef LH_DRV_PRECHECK_EN
            ST_SCAN: begin
                // Scans downward so the final byte checked is byte 0, which is
                // then already on rd_data for the first SEND cycle.
                if (!is_alnum(rd_data)) begin
                    scan_bad   = 1'b1;
                    state_next = ST_CHECK;
                end else if (idx == '0) begin
                    state_next = ST_SEND;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Result is computed from the values that will be held in CHECK.
        digest_nx = wait_hit ? digest_char : digest_out;
        match_c   = !accept && (digest_nx == exp_q) &&
                    !(err_invalid || err_inv_hit || scan_bad) &&
                    !(err_timeout || wait_expire) && !err_len;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptxt_char   <= NULL_CHAR;
            ptxt_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            digest_out  <= '0;
            match       <= 1'b0;
            err_len     <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;
            idx         <= '0;
            len_q       <= '0;
            cnt         <= '0;
            exp_q       <= '0;
            last_valid  <= 1'b0;
        end else begin
            busy       <= (state_next != ST_IDLE);
            done       <= (state_next == ST_CHECK);
            ptxt_valid <= (state_next == ST_SEND);
            ptxt_char  <= (state_next == ST_SEND) ? rd_data : NULL_CHAR;
            last_valid <= ptxt_valid;
            cnt        <= (state == ST_WAIT) ? cnt + CW'(1) : '0;

            if (state_next == ST_SEND) begin
                idx <= (state == ST_SEND) ? idx + LW'(1) : LW'(1);
`ifdef LH_DRV_PRECHECK_EN
            end else if (accept && !len_bad) begin
                idx <= msg_len - LW'(1);
            end else if (state == ST_SCAN) begin
                idx <= idx - LW'(1);
`endif
            end

            if (accept) begin
                len_q       <= msg_len;
                exp_q       <= exp_digest;
                err_len     <= len_bad;
                err_invalid <= 1'b0;
                err_timeout <= 1'b0;
                digest_out  <= '0;
                match       <= 1'b0;
            end

            if (err_inv_hit || scan_bad) begin
                err_invalid <= 1'b1;
            end
            if (wait_hit) begin
                digest_out <= digest_char;
            end
            if (wait_expire) begin
                err_timeout <= 1'b1;
            end
            if (state_next == ST_CHECK) begin
                match <= match_c;
            end
        end
    end

endmodule
